// File: rtl/hv_sign_stream_buf.sv
// Sign-vector accumulator with a packing FIFO feeding an AXI4-Stream master.
// Per-bit saturating counters are snapshotted on s_fin and streamed PACK per beat.
module hv_sign_stream_buf #(
  parameter int LANE        = 32,
  parameter int CNT_W       = 8,
  parameter int PACK        = 2,
  parameter int DEPTH       = 8,
  parameter int FRAME_BEATS = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     acc_v,
  input  logic [LANE-1:0]          result,
  input  logic                     s_fin,
  input  logic                     k_fin,
  output logic [LANE*PACK-1:0]     m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
  localparam logic [CNT_W-1:0] CMAX = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] CMIN = {1'b1, {(CNT_W-2){1'b0}}, 1'b1};
  localparam logic [BW-1:0] LAST_BEAT = BW'(FRAME_BEATS - 1);

  logic [CNT_W-1:0]     cnt    [LANE];
  logic [CNT_W-1:0]     cnt_nx [LANE];
  logic [LANE-1:0]      sign;
  logic [LANE-1:0]      mem    [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [LW-1:0]        level;
  logic [BW-1:0]        beat;
  logic [LANE*PACK-1:0] pack_data;
  logic                 free;
  logic                 pop;
  logic                 full;
  logic                 push;

  assign free = !m_axis_tvalid || m_axis_tready;
  assign pop  = free && (level >= LW'(PACK));
  assign full = (level == LW'(DEPTH));
  // a pop at the same edge frees room, so the write still lands
  assign push = s_fin && (!full || pop);

  assign fifo_level   = level;
  assign m_axis_tlast = m_axis_tvalid && (beat == LAST_BEAT);

  // saturating next-count and the sign it implies (tie gives 0)
  always_comb begin
    for (int i = 0; i < LANE; i++) begin
      cnt_nx[i] = cnt[i];
      if (acc_v) begin
        if (result[i]) begin
          if (cnt[i] != CMAX) cnt_nx[i] = cnt[i] + CNT_W'(1);
        end else begin
          if (cnt[i] != CMIN) cnt_nx[i] = cnt[i] - CNT_W'(1);
        end
      end
      sign[i] = !cnt_nx[i][CNT_W-1] && (cnt_nx[i] != '0);
    end
  end

  // gather the PACK oldest entries, oldest in the low lane
  always_comb begin
    pack_data = '0;
    for (int k = 0; k < PACK; k++) begin
      pack_data[k*LANE +: LANE] = mem[rd_ptr + AW'(k)];
    end
  end

  // bit counters: accumulate, cleared by either finish strobe
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANE; i++) begin
      if (rst || s_fin || k_fin) cnt[i] <= '0;
      else                       cnt[i] <= cnt_nx[i];
    end
  end

  // FIFO storage; contents need no reset since level gates reads
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= sign;
  end

  // FIFO pointers, level and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(PACK);
      level <= level + LW'(push) - (pop ? LW'(PACK) : '0);
      if (s_fin && !push) overflow <= 1'b1;
    end
  end

  // output beat register, held while the sink stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
    end else if (pop) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= pack_data;
    end else if (free) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  // frame beat counter, advances on each accepted beat
  always_ff @(posedge clk) begin
    if (rst) begin
      beat <= '0;
    end else if (m_axis_tvalid && m_axis_tready) begin
      beat <= (beat == LAST_BEAT) ? '0 : beat + BW'(1);
    end
  end

endmodule

// File: tb/tb_hv_sign_stream_buf.sv
// Bench for hv_sign_stream_buf: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_hv_sign_stream_buf;

  localparam int LANE  = 32;
  localparam int PACK  = 2;
  localparam int DEPTH = 8;
  localparam int FB    = 4;
  localparam int SAT   = 127;

  logic        clk = 1'b0;
  logic        rst;
  logic        acc_v;
  logic [31:0] result;
  logic        s_fin;
  logic        k_fin;
  logic        tready;
  logic [63:0] tdata;
  logic        tvalid;
  logic        tlast;
  logic [3:0]  level;
  logic        ovf;

  hv_sign_stream_buf #(
    .LANE(LANE), .CNT_W(8), .PACK(PACK), .DEPTH(DEPTH), .FRAME_BEATS(FB)
  ) dut (
    .clk(clk), .rst(rst), .acc_v(acc_v), .result(result),
    .s_fin(s_fin), .k_fin(k_fin),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid),
    .m_axis_tready(tready), .m_axis_tlast(tlast),
    .fifo_level(level), .overflow(ovf)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  int          mcnt [LANE];
  logic [31:0] mq [$];
  bit          mvalid;
  logic [63:0] mdata;
  int          mbeat;
  bit          movf;

  int hs_cnt;
  int last_mask;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: what the next edge must produce from the current inputs.
  task automatic model_edge();
    int nc;
    logic [31:0] sv;
    bit free, pop;
    if (rst) begin
      foreach (mcnt[i]) mcnt[i] = 0;
      mq.delete();
      mvalid = 0;
      mdata  = '0;
      mbeat  = 0;
      movf   = 0;
      return;
    end
    free = !mvalid || tready;
    pop  = free && (mq.size() >= PACK);
    sv   = '0;
    for (int i = 0; i < LANE; i++) begin
      nc = mcnt[i];
      if (acc_v) nc = nc + (result[i] ? 1 : -1);
      if (nc > SAT)  nc = SAT;
      if (nc < -SAT) nc = -SAT;
      sv[i] = (nc > 0);
      mcnt[i] = (s_fin || k_fin) ? 0 : nc;
    end
    if (mvalid && tready) mbeat = (mbeat + 1) % FB;
    if (pop) begin
      for (int k = 0; k < PACK; k++) mdata[k*32 +: 32] = mq.pop_front();
      mvalid = 1;
    end else if (free) begin
      mvalid = 0;
    end
    if (s_fin) begin
      if (mq.size() < DEPTH) mq.push_back(sv);
      else                   movf = 1;
    end
  endtask

  task automatic step();
    logic pv, pr, pl, prst;
    logic [63:0] pd;
    bit hs;
    pv = tvalid; pr = tready; pd = tdata; pl = tlast; prst = rst;
    hs = (tvalid === 1'b1) && tready && !rst;
    model_edge();
    @(posedge clk);
    #1;
    if (hs) begin
      hs_cnt++;
      if (pl) last_mask |= (1 << hs_cnt);
    end
    check("tvalid", tvalid, mvalid);
    check("level", level, mq.size());
    check("overflow", ovf, movf);
    check("tlast", tlast, mvalid && (mbeat == FB - 1));
    if (mvalid) check("tdata", tdata, mdata);
    if (!prst && pv === 1'b1 && !pr) begin
      check("stall_tvalid", tvalid, 1'b1);
      check("stall_tdata", tdata, pd);
      check("stall_tlast", tlast, pl);
    end
  endtask

  task automatic clr_in();
    rst = 0; acc_v = 0; s_fin = 0; k_fin = 0; result = '0;
  endtask

  task automatic idle(int n);
    clr_in();
    repeat (n) step();
  endtask

  task automatic acc(logic [31:0] r, int n);
    clr_in();
    acc_v = 1; result = r;
    repeat (n) step();
    clr_in();
  endtask

  task automatic fin();
    clr_in();
    s_fin = 1;
    step();
    clr_in();
  endtask

  task automatic acc_fin(logic [31:0] r);
    clr_in();
    acc_v = 1; s_fin = 1; result = r;
    step();
    clr_in();
  endtask

  task automatic do_reset();
    clr_in();
    rst = 1;
    step();
    clr_in();
  endtask

  logic [31:0] v [12];
  int mode;

  initial begin
    clr_in();
    tready = 1;
    do_reset();
    do_reset();
    check("rst_tvalid", tvalid, 1'b0);
    check("rst_tlast", tlast, 1'b0);
    check("rst_tdata", tdata, 64'h0);
    check("rst_level", level, 4'd0);
    check("rst_ovf", ovf, 1'b0);

    // 1: two opposite vectors form one beat
    acc(32'hFFFF_FFFF, 3);
    fin();
    acc(32'h0000_0000, 3);
    fin();
    check("t1_level2", level, 4'd2);
    check("t1_notyet", tvalid, 1'b0);
    idle(1);
    check("t1_tvalid", tvalid, 1'b1);
    check("t1_tdata", tdata, 64'h0000_0000_FFFF_FFFF);
    idle(2);

    // 2: saturation at +127 (no wrap) and tie gives 0
    acc(32'h0000_0001, 200);
    fin();
    acc(32'h0000_0001, 200);
    acc(32'h0000_0000, 127);
    fin();
    idle(1);
    check("t2_tdata", tdata, 64'h0000_0000_0000_0001);
    idle(2);

    // 5: same-cycle sample included; k_fin clears without writing
    acc_fin(32'hA5A5_0F0F);
    acc_fin(32'h1234_5678);
    idle(1);
    check("t5_same_cycle", tdata, 64'h1234_5678_A5A5_0F0F);
    idle(2);
    acc_fin(32'hFFFF_FFFF);
    acc(32'hFFFF_FFFF, 3);
    k_fin = 1;
    step();
    clr_in();
    check("t5_kfin_level", level, 4'd1);
    acc_fin(32'h0000_00F0);
    idle(1);
    check("t5_kfin_tdata", tdata, 64'h0000_00F0_FFFF_FFFF);
    idle(2);

    // 3: fill under backpressure until a vector is dropped
    do_reset();
    tready = 0;
    for (int i = 0; i < 11; i++) begin
      v[i] = $urandom;
      acc_fin(v[i]);
      if (i == 9) begin
        check("t3_level_full", level, 4'd8);
        check("t3_no_ovf", ovf, 1'b0);
      end
    end
    check("t3_ovf", ovf, 1'b1);
    check("t3_level_held", level, 4'd8);
    check("t3_first_beat", tdata, {v[1], v[0]});
    tready = 1;
    idle(12);
    check("t3_drained", level, 4'd0);

    // 4: framing with FRAME_BEATS=4 over 10 beats
    do_reset();
    hs_cnt = 0;
    last_mask = 0;
    tready = 1;
    for (int i = 0; i < 20; i++) acc_fin($urandom);
    idle(4);
    check("t4_beats", hs_cnt, 10);
    check("t4_tlast_pos", last_mask, (1 << 4) | (1 << 8));

    // 6: reset overrides a pending beat, queued data and a write
    do_reset();
    tready = 0;
    for (int i = 0; i < 7; i++) acc_fin($urandom);
    check("t6_pre_tvalid", tvalid, 1'b1);
    check("t6_pre_level", level, 4'd5);
    rst = 1; s_fin = 1; acc_v = 1; result = $urandom;
    step();
    clr_in();
    check("t6_tvalid", tvalid, 1'b0);
    check("t6_level", level, 4'd0);
    check("t6_ovf", ovf, 1'b0);
    check("t6_tdata", tdata, 64'h0);

    // random traffic with phases of light, heavy and mixed backpressure
    for (int i = 0; i < 3000; i++) begin
      mode   = (i / 150) % 3;
      rst    = ($urandom_range(0, 799) == 0);
      acc_v  = $urandom_range(0, 3) != 0;
      result = $urandom;
      s_fin  = $urandom_range(0, 2) == 0;
      k_fin  = $urandom_range(0, 15) == 0;
      case (mode)
        0:       tready = $urandom_range(0, 9) == 0;
        1:       tready = $urandom_range(0, 9) != 0;
        default: tready = $urandom_range(0, 1) == 1;
      endcase
      step();
    end
    clr_in();
    tready = 1;
    idle(10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
